m2_expbus_reg_slave: RTL and testbench
======================================

// Module: m2_expbus_reg_slave
// PURPOSE
//  Parametrised expansion-bus register slave for the M2 compute FPGA. It replaces the fixed EXPBUS termination in the board infrastructure.
//  Decodes the host's multiplexed address/data bus into a ID/IRQ/status block plus NUM_REGS 16-bit control registers driven into fabric.
//  Adds configurable wait states, byte-lane writes and a maskable interrupt aggregator driving o_fpga_intr.
// PARAMETERS
//  C_FPGA_ID    1   8-bit FPGA id, returned in ID register [7:0]
//  C_VERSION    1   8-bit version, returned in ID register [15:8]
//  NUM_REGS     8   control registers, 1..64
//  ADDR_W       8   address bits latched from data bus, >= clog2(NUM_REGS+4)
//  WAIT_STATES  0   extra cycles between data phase start and ready, 0..15
//  IRQ_W        4   interrupt sources, 1..16
//  TIMEOUT      255 stall limit in cycles (REG_BUS_TIMEOUT_EN only)
// PORTS
//  i_clk               in  1            system clock; forwarded unchanged as o_fpga_reg_clk
//  i_rst_z             in  1            async reset, active low
//  o_fpga_reg_clk      out 1            bus clock to host (= i_clk)
//  i_fpga_reg_en_z     in  1            transaction enable, active low
//  i_fpga_reg_ads_z    in  1            address strobe, active low
//  i_fpga_reg_uds_z    in  1            upper byte strobe [15:8], active low
//  i_fpga_reg_lds_z    in  1            lower byte strobe [7:0], active low
//  i_fpga_reg_rd_wr_z  in  1            1=read, 0=write
//  o_fpga_reg_rdy_z    out 1            ready/ack, active low
//  o_fpga_intr         out 1            interrupt, active high
//  b_reg_data_I        in  16           bus data in
//  b_reg_data_O        out 16           bus data out
//  b_reg_data_T        out 1            tristate, 1=high-Z
//  i_irq_src           in  IRQ_W        fabric interrupt sources, rising-edge sensitive
//  o_ctrl              out NUM_REGS*16  control regs, reg k at [16k+15:16k]
//  o_wr_pulse          out NUM_REGS     1-cycle strobe per reg on committed write
// BEHAVIOUR
//  Reset: FSM=IDLE, rdy_z=1, T=1, O=0, intr=0, ctrl=0, wr_pulse=0, pending=0, mask=0, err=0. Async assert; sync deassert internally.
//  Inputs sampled on rising i_clk. Map: 0 ID(RO) 1 IRQ_PEND(RW1C) 2 IRQ_MASK(RW) 3 STATUS(bit0 bad addr, bit1 timeout; RW1C) 4..4+NUM_REGS-1 CTRL(RW).
//  FSM IDLE->ADDR: en_z=0 & ads_z=0; latch data_I[ADDR_W-1:0] and rd_wr_z.
//  ADDR->WAIT: ads_z=1 & en_z=0; wait counter loaded with WAIT_STATES.
//  WAIT->ACK: when counter hits 0 (WAIT_STATES=0: one cycle in WAIT).
//  ACK: rdy_z=0 exactly 1 cycle. Write commits on byte lanes with uds/lds low that cycle; new value visible next cycle; wr_pulse high same cycle as commit.
//  ACK->HOLD. Read: data_O valid and T=0 from ACK until en_z=1.
//  HOLD->IDLE: en_z=1; T=1 same cycle.
//  Any state: en_z=1 before ACK -> IDLE, no commit, no error.
//  Latency, ads_z rise to rdy_z low: WAIT_STATES+2 cycles.
//  Unmapped address: read returns 16'hDEAD, write dropped, STATUS[0] set. ID writes ignored silently.
//  IRQ: rising edge of i_irq_src[n] (registered compare) sets pending[n]. Write 1 to IRQ_PEND clears bit.
//  IRQ edge and W1C on same bit in same cycle: set wins.
//  o_fpga_intr = |(pending & mask), registered (1-cycle lag). Bits >= IRQ_W read 0.
//  Reset mid-transaction: immediate IDLE, rdy_z=1, T=1, no commit.
// CONFIGURATION
//  REG_BUS_TIMEOUT_EN defined: counter runs in ADDR/WAIT/HOLD.
//    On reaching TIMEOUT cycles: force IDLE, T=1, set STATUS[1], rdy_z stays 1.
//    Counter clears on any state change.
//  Undefined: no counter, STATUS[1] reads 0, FSM waits indefinitely.
// TESTING
//  WAIT_STATES=2: write addr 4 data 16'h1234 uds=lds=0 -> rdy_z low 4 cycles after ads_z rise; o_ctrl[15:0]=1234; wr_pulse[0] 1 cycle.
//  Write addr 5 data 16'hABCD lds=0 uds=1, prior 0 -> reg1=16'h00CD; read addr 0 -> {C_VERSION,C_FPGA_ID}=16'h0101.
//  mask=4'b0010; pulse irq_src[1] -> pending=2, intr=1; write 16'h0002 to addr 1 -> intr=0.
//  irq_src[1] edge same cycle as W1C of bit 1 -> pending[1] remains 1.
//  Read addr 8'hF0 -> 16'hDEAD, STATUS=1; drop en_z in WAIT -> no rdy_z, regs unchanged.
//  REG_BUS_TIMEOUT_EN, TIMEOUT=10: hold en_z=0 after ACK 10 cycles -> IDLE, T=1, STATUS[1]=1; assert i_rst_z=0 in WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/m2_expbus_reg_slave.sv
// ---------------------------------------------------------------------------
// m2_expbus_reg_slave
//   Register slave for the host's multiplexed address/data expansion bus.
//   Address map (word addresses latched during the address phase):
//     0 ID {C_VERSION, C_FPGA_ID} (read-only, writes ignored)
//     1 IRQ_PEND (write 1 to clear)
//     2 IRQ_MASK (read/write)
//     3 STATUS   bit0 bad address, bit1 timeout (write 1 to clear)
//     4 .. 4+NUM_REGS-1  CTRL registers, driven out on o_ctrl
//   Writes honour the byte-lane strobes. Reads of unmapped addresses
//   return 16'hDEAD and set STATUS[0].
//
//   Optional feature: define REG_BUS_TIMEOUT_EN to abort transactions that
//   stall in ADDR/WAIT/HOLD for TIMEOUT cycles. The abort sets STATUS[1].
//
// Ports
//   i_clk, i_rst_z        clock, asynchronous active-low reset
//   o_fpga_reg_clk        bus clock to host (i_clk forwarded)
//   i_fpga_reg_en_z       transaction enable (active low)
//   i_fpga_reg_ads_z      address strobe (active low)
//   i_fpga_reg_uds_z/lds_z byte strobes [15:8]/[7:0] (active low)
//   i_fpga_reg_rd_wr_z    1 = read, 0 = write
//   o_fpga_reg_rdy_z      ready, low for exactly one cycle per transfer
//   o_fpga_intr           |(pending & mask), registered
//   b_reg_data_I/_O/_T    bus data in / out / tristate (1 = high-Z)
//   i_irq_src             fabric interrupt sources (rising-edge)
//   o_ctrl, o_wr_pulse    control registers and per-register write strobes
// ---------------------------------------------------------------------------
module m2_expbus_reg_slave #(
   parameter int C_FPGA_ID   = 1,
   parameter int C_VERSION   = 1,
   parameter int NUM_REGS    = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int IRQ_W       = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst_z,
   output logic                    o_fpga_reg_clk,
   input  logic                    i_fpga_reg_en_z,
   input  logic                    i_fpga_reg_ads_z,
   input  logic                    i_fpga_reg_uds_z,
   input  logic                    i_fpga_reg_lds_z,
   input  logic                    i_fpga_reg_rd_wr_z,
   output logic                    o_fpga_reg_rdy_z,
   output logic                    o_fpga_intr,
   input  logic [15:0]             b_reg_data_I,
   output logic [15:0]             b_reg_data_O,
   output logic                    b_reg_data_T,
   input  logic [IRQ_W-1:0]        i_irq_src,
   output logic [NUM_REGS*16-1:0]  o_ctrl,
   output logic [NUM_REGS-1:0]     o_wr_pulse
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ACK, S_HOLD} state_t;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_reg;
   logic       rst_n;
   always_ff @(posedge i_clk or negedge i_rst_z) begin
      if (!i_rst_z) rst_sync_reg <= 2'b00;
      else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n = rst_sync_reg[1];

   assign o_fpga_reg_clk = i_clk;

   state_t            state_reg, state_next;
   logic [3:0]        wcnt_reg, wcnt_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              rd_reg;
   logic              timeout_hit;
   logic [IRQ_W-1:0]  pending_reg, pending_next, mask_reg, irq_prev_reg, pend_clr;
   logic [1:0]        status_reg, status_next, stat_clr;
   logic              intr_reg;
   logic [15:0]       data_o_reg, rdata_mux, lane_mask, wdata_lane, pend16, mask16;
   logic [31:0]       addr32;
   logic              ack_cycle, wr_cycle, addr_ok;
   logic              hit_id, hit_pend, hit_mask, hit_stat;
   logic [NUM_REGS-1:0] ctrl_hit;

   // ---------------- bus FSM ----------------
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      case (state_reg)
         S_IDLE: if (!i_fpga_reg_en_z && !i_fpga_reg_ads_z) state_next = S_ADDR;
         S_ADDR: begin
            if (i_fpga_reg_en_z) state_next = S_IDLE;
            else if (i_fpga_reg_ads_z) begin
               state_next = S_WAIT;
               wcnt_next  = 4'(WAIT_STATES);
            end
         end
         S_WAIT: begin
            if (i_fpga_reg_en_z)     state_next = S_IDLE;
            else if (wcnt_reg == '0) state_next = S_ACK;
            else                     wcnt_next  = wcnt_reg - 4'd1;
         end
         S_ACK:  state_next = i_fpga_reg_en_z ? S_IDLE : S_HOLD;
         S_HOLD: if (i_fpga_reg_en_z) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (timeout_hit) state_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         wcnt_reg  <= '0;
         addr_reg  <= '0;
         rd_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         if (state_reg == S_IDLE && state_next == S_ADDR) begin
            addr_reg <= b_reg_data_I[ADDR_W-1:0];
            rd_reg   <= i_fpga_reg_rd_wr_z;
         end
      end
   end

`ifdef REG_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_reg;
   logic            to_state;
   assign to_state    = (state_reg == S_ADDR) || (state_reg == S_WAIT) || (state_reg == S_HOLD);
   assign timeout_hit = to_state && (to_cnt_reg == TO_W'(TIMEOUT - 1));
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n)                                       to_cnt_reg <= '0;
      else if (!to_state || state_next != state_reg)    to_cnt_reg <= '0;
      else                                              to_cnt_reg <= to_cnt_reg + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // ---------------- decode ----------------
   assign ack_cycle  = (state_reg == S_ACK);
   assign wr_cycle   = ack_cycle && !rd_reg;
   assign lane_mask  = {{8{~i_fpga_reg_uds_z}}, {8{~i_fpga_reg_lds_z}}};
   assign wdata_lane = b_reg_data_I & lane_mask;
   assign addr32     = 32'(addr_reg);
   assign hit_id     = (addr32 == 32'd0);
   assign hit_pend   = (addr32 == 32'd1);
   assign hit_mask   = (addr32 == 32'd2);
   assign hit_stat   = (addr32 == 32'd3);
   assign addr_ok    = hit_id || hit_pend || hit_mask || hit_stat || (|ctrl_hit);

   always_comb begin
      pend16 = '0;
      mask16 = '0;
      pend16[IRQ_W-1:0] = pending_reg;
      mask16[IRQ_W-1:0] = mask_reg;
      rdata_mux = 16'hDEAD;
      if (hit_id)   rdata_mux = {8'(C_VERSION), 8'(C_FPGA_ID)};
      if (hit_pend) rdata_mux = pend16;
      if (hit_mask) rdata_mux = mask16;
      if (hit_stat) rdata_mux = {14'd0, status_reg};
      for (int k = 0; k < NUM_REGS; k++)
         if (ctrl_hit[k]) rdata_mux = o_ctrl[16*k +: 16];
   end

   // ---------------- control registers ----------------
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl
         logic [15:0] ctrl_reg;
         assign ctrl_hit[gi]   = (addr32 == 32'(gi + 4));
         // Strobe is asserted in the ACK cycle; the new value lands on the
         // following edge.
         assign o_wr_pulse[gi] = wr_cycle && ctrl_hit[gi] && (|lane_mask);
         always_ff @(posedge i_clk or negedge rst_n) begin
            if (!rst_n)              ctrl_reg <= '0;
            else if (o_wr_pulse[gi]) ctrl_reg <= (ctrl_reg & ~lane_mask) | wdata_lane;
         end
         assign o_ctrl[16*gi +: 16] = ctrl_reg;
      end
   endgenerate

   // ---------------- interrupts and status ----------------
   // Set terms are OR-ed in after the clear so a coincident event wins.
   assign pend_clr     = (wr_cycle && hit_pend) ? wdata_lane[IRQ_W-1:0] : '0;
   assign pending_next = (pending_reg & ~pend_clr) | (i_irq_src & ~irq_prev_reg);
   assign stat_clr     = (wr_cycle && hit_stat) ? wdata_lane[1:0] : 2'b00;
   assign status_next  = (status_reg & ~stat_clr) | {timeout_hit, ack_cycle && !addr_ok};

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg  <= '0;
         mask_reg     <= '0;
         irq_prev_reg <= '0;
         status_reg   <= '0;
         intr_reg     <= 1'b0;
         data_o_reg   <= '0;
      end else begin
         irq_prev_reg <= i_irq_src;
         pending_reg  <= pending_next;
         status_reg   <= status_next;
         intr_reg     <= |(pending_reg & mask_reg);
         if (wr_cycle && hit_mask)
            mask_reg <= (mask_reg & ~lane_mask[IRQ_W-1:0]) | wdata_lane[IRQ_W-1:0];
         // Read data is snapshotted on entry to ACK and held until release.
         if (state_reg == S_WAIT && state_next == S_ACK && rd_reg) data_o_reg <= rdata_mux;
         else if (state_next == S_IDLE)                             data_o_reg <= '0;
      end
   end

   assign o_fpga_intr      = intr_reg;
   assign o_fpga_reg_rdy_z = !ack_cycle;
   assign b_reg_data_O     = data_o_reg;
   // Bus released combinationally as soon as the host drops enable.
   assign b_reg_data_T     = !(rd_reg && (ack_cycle || state_reg == S_HOLD) && !i_fpga_reg_en_z);

endmodule

// File: tb/tb_m2_expbus_reg_slave.sv
// Directed testbench for m2_expbus_reg_slave (WAIT_STATES=2, NUM_REGS=8).
module tb_m2_expbus_reg_slave;

   logic         clk = 1'b0;
   logic         rst_z;
   logic         en_z, ads_z, uds_z, lds_z, rd_wr_z;
   logic [15:0]  data_i;
   logic [3:0]   irq_src;
   logic         reg_clk, rdy_z, intr, data_t;
   logic [15:0]  data_o;
   logic [127:0] ctrl;
   logic [7:0]   wr_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   logic [7:0]   ack_pulse, hold_pulse;
   logic [127:0] ack_ctrl, hold_ctrl;
   logic [15:0]  ack_data, hold_data;
   logic         hold_rdy, hold_t, rel_t;

   always #5 clk = ~clk;

   m2_expbus_reg_slave #(
      .C_FPGA_ID(1), .C_VERSION(1), .NUM_REGS(8), .ADDR_W(8),
      .WAIT_STATES(2), .IRQ_W(4), .TIMEOUT(10)
   ) dut (
      .i_clk(clk), .i_rst_z(rst_z), .o_fpga_reg_clk(reg_clk),
      .i_fpga_reg_en_z(en_z), .i_fpga_reg_ads_z(ads_z),
      .i_fpga_reg_uds_z(uds_z), .i_fpga_reg_lds_z(lds_z),
      .i_fpga_reg_rd_wr_z(rd_wr_z), .o_fpga_reg_rdy_z(rdy_z),
      .o_fpga_intr(intr), .b_reg_data_I(data_i), .b_reg_data_O(data_o),
      .b_reg_data_T(data_t), .i_irq_src(irq_src), .o_ctrl(ctrl),
      .o_wr_pulse(wr_pulse)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full bus transfer; irq_at_ack is driven onto i_irq_src in the ACK cycle.
   task automatic xfer(input logic rd, input logic [7:0] addr, input logic [15:0] wdata,
                       input logic uds, input logic lds, input logic [3:0] irq_at_ack);
      logic got_rdy;
      @(negedge clk);
      en_z = 1'b0; ads_z = 1'b0; rd_wr_z = rd; data_i = {8'h00, addr};
      @(negedge clk);
      ads_z = 1'b1; data_i = rd ? 16'h0000 : wdata; uds_z = uds; lds_z = lds;
      lat = 0; got_rdy = 1'b0;
      for (int i = 0; i < 20 && !got_rdy; i++) begin
         @(negedge clk);
         lat++;
         if (rdy_z == 1'b0) got_rdy = 1'b1;
      end
      if (!got_rdy) check("rdy_seen", 32'(got_rdy), 32'd1);
      ack_pulse = wr_pulse; ack_ctrl = ctrl; ack_data = data_o;
      irq_src = irq_at_ack;
      @(negedge clk);
      hold_pulse = wr_pulse; hold_ctrl = ctrl; hold_rdy = rdy_z; hold_t = data_t; hold_data = data_o;
      en_z = 1'b1; uds_z = 1'b1; lds_z = 1'b1;
      #1 rel_t = data_t;
      $display("xfer %s addr=%h wdata=%h uds=%b lds=%b lat=%0d rdata=%h",
               rd ? "RD" : "WR", addr, wdata, uds, lds, lat, hold_data);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [15:0] exp);
      xfer(1'b1, addr, 16'h0000, 1'b1, 1'b1, irq_src);
      check(tag, 32'(hold_data), 32'(exp));
   endtask

   task automatic wr(input logic [7:0] addr, input logic [15:0] d);
      xfer(1'b0, addr, d, 1'b0, 1'b0, irq_src);
   endtask

   initial begin
      logic seen;
      rst_z = 1'b1; en_z = 1'b1; ads_z = 1'b1; uds_z = 1'b1; lds_z = 1'b1;
      rd_wr_z = 1'b1; data_i = '0; irq_src = '0;
      #2 rst_z = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdy", 32'(rdy_z), 32'd1);
      check("rst_T", 32'(data_t), 32'd1);
      check("rst_O", 32'(data_o), 32'd0);
      check("rst_intr", 32'(intr), 32'd0);
      check("rst_ctrl", 32'(|ctrl), 32'd0);
      check("rst_pulse", 32'(wr_pulse), 32'd0);
      rst_z = 1'b1;
      repeat (4) @(negedge clk);

      // full-width write, latency and strobe timing
      xfer(1'b0, 8'h04, 16'h1234, 1'b0, 1'b0, 4'h0);
      check("wr_latency", 32'(lat), 32'd4);
      check("wr_pulse_ack", 32'(ack_pulse), 32'h01);
      check("ctrl0_before", 32'(ack_ctrl[15:0]), 32'h0000);
      check("ctrl0_after", 32'(hold_ctrl[15:0]), 32'h1234);
      check("wr_pulse_hold", 32'(hold_pulse), 32'h00);
      check("rdy_one_cycle", 32'(hold_rdy), 32'd1);

      // lower lane only
      xfer(1'b0, 8'h05, 16'hABCD, 1'b1, 1'b0, 4'h0);
      check("ctrl1_lds", 32'(hold_ctrl[31:16]), 32'h00CD);
      check("wr_pulse1", 32'(ack_pulse), 32'h02);

      // ID read and tristate behaviour
      rd_chk("id_read", 8'h00, 16'h0101);
      check("id_ack_data", 32'(ack_data), 32'h0101);
      check("rd_T_hold", 32'(hold_t), 32'd0);
      check("rd_T_release", 32'(rel_t), 32'd1);
      check("rd_no_pulse", 32'(ack_pulse), 32'h00);
      rd_chk("ctrl0_read", 8'h04, 16'h1234);

      // mask and interrupt
      wr(8'h02, 16'h0002);
      rd_chk("mask_read", 8'h02, 16'h0002);
      @(negedge clk); irq_src = 4'b0010;
      @(negedge clk); check("intr_lag", 32'(intr), 32'd0); irq_src = 4'b0000;
      @(negedge clk); check("intr_set", 32'(intr), 32'd1);
      rd_chk("pend_read", 8'h01, 16'h0002);
      wr(8'h01, 16'h0002);
      @(negedge clk); check("intr_clr", 32'(intr), 32'd0);
      rd_chk("pend_cleared", 8'h01, 16'h0000);

      // masked source: pending but no interrupt
      @(negedge clk); irq_src = 4'b0001;
      @(negedge clk); irq_src = 4'b0000;
      repeat (2) @(negedge clk);
      check("intr_masked", 32'(intr), 32'd0);
      rd_chk("pend_masked", 8'h01, 16'h0001);
      wr(8'h01, 16'h0001);
      rd_chk("pend_masked_clr", 8'h01, 16'h0000);

      // edge coincident with W1C of the same bit: set wins
      xfer(1'b0, 8'h01, 16'h0002, 1'b0, 1'b0, 4'b0010);
      irq_src = 4'b0000;
      rd_chk("set_wins", 8'h01, 16'h0002);
      wr(8'h01, 16'h0002);
      rd_chk("set_wins_clr", 8'h01, 16'h0000);

      // unmapped address
      rd_chk("bad_addr_read", 8'hF0, 16'hDEAD);
      rd_chk("status_bad", 8'h03, 16'h0001);
      wr(8'h03, 16'h0001);
      rd_chk("status_clr", 8'h03, 16'h0000);

      // ID write ignored without error
      wr(8'h00, 16'hFFFF);
      rd_chk("id_unchanged", 8'h00, 16'h0101);
      rd_chk("id_wr_no_err", 8'h03, 16'h0000);

      // abort in WAIT
      @(negedge clk); en_z = 1'b0; ads_z = 1'b0; rd_wr_z = 1'b0; data_i = 16'h0004;
      @(negedge clk); ads_z = 1'b1; data_i = 16'hFFFF; uds_z = 1'b0; lds_z = 1'b0;
      @(negedge clk); en_z = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rdy_z == 1'b0 || wr_pulse != 8'h00) seen = 1'b1;
      end
      uds_z = 1'b1; lds_z = 1'b1;
      $display("xfer WR addr=04 wdata=ffff aborted in WAIT");
      check("abort_no_rdy", 32'(seen), 32'd0);
      rd_chk("abort_no_commit", 8'h04, 16'h1234);
      rd_chk("abort_no_err", 8'h03, 16'h0000);

`ifdef REG_BUS_TIMEOUT_EN
      begin
         logic got;
         @(negedge clk); en_z = 1'b0; ads_z = 1'b0; rd_wr_z = 1'b1; data_i = 16'h0000;
         @(negedge clk); ads_z = 1'b1;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rdy_z == 1'b0) got = 1'b1;
         end
         check("to_rdy_seen", 32'(got), 32'd1);
         repeat (5) @(negedge clk);
         check("to_T_early", 32'(data_t), 32'd0);
         repeat (7) @(negedge clk);
         check("to_T_forced", 32'(data_t), 32'd1);
         check("to_rdy", 32'(rdy_z), 32'd1);
         en_z = 1'b1;
         $display("xfer RD addr=00 held past timeout");
         rd_chk("status_timeout", 8'h03, 16'h0002);
         wr(8'h03, 16'h0002);
      end
`endif

      // reset in WAIT
      @(negedge clk); en_z = 1'b0; ads_z = 1'b0; rd_wr_z = 1'b0; data_i = 16'h0004;
      @(negedge clk); ads_z = 1'b1; data_i = 16'h5555; uds_z = 1'b0; lds_z = 1'b0;
      @(negedge clk); rst_z = 1'b0;
      #1;
      $display("xfer WR addr=04 wdata=5555 reset in WAIT");
      check("mid_rst_rdy", 32'(rdy_z), 32'd1);
      check("mid_rst_T", 32'(data_t), 32'd1);
      check("mid_rst_O", 32'(data_o), 32'd0);
      check("mid_rst_ctrl", 32'(|ctrl), 32'd0);
      check("mid_rst_pulse", 32'(wr_pulse), 32'd0);
      check("mid_rst_intr", 32'(intr), 32'd0);
      en_z = 1'b1; uds_z = 1'b1; lds_z = 1'b1;
      @(negedge clk); rst_z = 1'b1;
      repeat (4) @(negedge clk);
      rd_chk("post_rst_ctrl0", 8'h04, 16'h0000);
      rd_chk("post_rst_mask", 8'h02, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
